// File: rtl/adder_subtractor_pipe_nbit.sv
// Pipelined n-bit adder/subtractor: the carry chain is cut into STAGES equal chunks.
// Optional feature macro ADDSUB_OVF_EN: registers the MSB carry-in and presents signed overflow.
module adder_subtractor_pipe_nbit #(
    parameter int n      = 16,
    parameter int STAGES = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [n-1:0] x,
    input  logic [n-1:0] y,
    input  logic         add_n,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [n-1:0] sum,
    output logic         cout,
    output logic         ovf
);
    localparam int C    = n / STAGES;
    localparam int LAST = STAGES - 1;

    logic [n-1:0]      x_q  [STAGES];
    logic [n-1:0]      x_d  [STAGES];
    logic [n-1:0]      yi_q [STAGES];
    logic [n-1:0]      yi_d [STAGES];
    logic [n-1:0]      s_q  [STAGES];
    logic [n-1:0]      s_d  [STAGES];
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] v_d;
    logic [STAGES-1:0] c_q;
    logic [STAGES-1:0] c_d;
    logic              adv_s;

    // Adds chunk k of xs and ys with carry-in; returns {carry_out, partial sum with chunk k filled in}.
    function automatic logic [n:0] chunk_add(input logic [n-1:0] xs, input logic [n-1:0] ys,
                                             input logic [n-1:0] ss, input logic cin, input int k);
        logic [C:0]   part;
        logic [n-1:0] so;
        part = {1'b0, xs[k*C +: C]} + {1'b0, ys[k*C +: C]} + {{C{1'b0}}, cin};
        so = ss;
        so[k*C +: C] = part[C-1:0];
        return {part[C], so};
    endfunction

    // The whole pipe advances in lockstep unless a presented result is being held back.
    assign adv_s     = !(v_q[LAST] && !out_ready);
    assign in_ready  = adv_s;
    assign out_valid = v_q[LAST];
    assign sum       = s_q[LAST];
    assign cout      = c_q[LAST];

    // Next-state for every stage: shift one chunk of carry chain per stage, or hold on stall.
    always_comb begin
        logic [n:0] r_s;
        r_s  = '0;
        x_d  = x_q;
        yi_d = yi_q;
        s_d  = s_q;
        v_d  = v_q;
        c_d  = c_q;
        if (adv_s) begin
            r_s     = chunk_add(x, y ^ {n{add_n}}, '0, add_n, 0);
            x_d[0]  = x;
            yi_d[0] = y ^ {n{add_n}};
            s_d[0]  = r_s[n-1:0];
            c_d[0]  = r_s[n];
            v_d[0]  = in_valid;
            for (int k = 1; k < STAGES; k++) begin
                r_s     = chunk_add(x_q[k-1], yi_q[k-1], s_q[k-1], c_q[k-1], k);
                x_d[k]  = x_q[k-1];
                yi_d[k] = yi_q[k-1];
                s_d[k]  = r_s[n-1:0];
                c_d[k]  = r_s[n];
                v_d[k]  = v_q[k-1];
            end
        end else begin
            v_d = v_q;
            c_d = c_q;
        end
    end

    // Stage registers; reset discards everything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                x_q[k]  <= '0;
                yi_q[k] <= '0;
                s_q[k]  <= '0;
            end
            v_q <= '0;
            c_q <= '0;
        end else begin
            x_q  <= x_d;
            yi_q <= yi_d;
            s_q  <= s_d;
            v_q  <= v_d;
            c_q  <= c_d;
        end
    end

`ifdef ADDSUB_OVF_EN
    logic cmsb_q;
    logic cmsb_d;

    // Carry into the MSB is recovered from the MSB sum bit and its two operand bits.
    always_comb begin
        cmsb_d = x_d[LAST][n-1] ^ yi_d[LAST][n-1] ^ s_d[LAST][n-1];
    end

    // MSB carry-in register, kept aligned with the final stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmsb_q <= 1'b0;
        end else begin
            cmsb_q <= cmsb_d;
        end
    end

    assign ovf = cmsb_q ^ c_q[LAST];
`else
    assign ovf = 1'b0;
`endif
endmodule

// File: tb/tb_adder_subtractor_pipe_nbit.sv
// Randomized + directed bench for adder_subtractor_pipe_nbit (n=16, STAGES=4) against a queue model.
module tb_adder_subtractor_pipe_nbit;
    localparam int N   = 16;
    localparam int LAT = 4;
`ifdef ADDSUB_OVF_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    typedef struct {
        logic [N-1:0] sum;
        logic         cout;
        logic         ovf;
        int           acc;
        int           sacc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] x = '0;
    logic [N-1:0] y = '0;
    logic         add_n = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [N-1:0] sum;
    logic         cout;
    logic         ovf;

    exp_t exq[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   stall_cnt = 0;
    int   n_delivered = 0;
    logic last_acc = 1'b0;

    adder_subtractor_pipe_nbit #(.n(N), .STAGES(LAT)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .add_n(add_n), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b, input logic sub);
        exp_t        e;
        int unsigned r;
        if (sub) begin
            e.sum  = a - b;
            e.cout = (a >= b);
            e.ovf  = (a[N-1] != b[N-1]) && (e.sum[N-1] != a[N-1]);
        end else begin
            r      = a + b;
            e.sum  = r[N-1:0];
            e.cout = r[N];
            e.ovf  = (a[N-1] == b[N-1]) && (e.sum[N-1] != a[N-1]);
        end
        e.ovf  = e.ovf & OVF_ON;
        e.acc  = 0;
        e.sacc = 0;
        return e;
    endfunction

    // One clock cycle: check outputs mid-cycle, update the model, then advance past the edge.
    task automatic step();
        logic exp_v;
        logic stalled;
        exp_t e;
        @(negedge clk);
        last_acc = 1'b0;
        if (rst) begin
            exq.delete();
        end else begin
            exp_v = (exq.size() > 0) && (cyc >= exq[0].acc + LAT + (stall_cnt - exq[0].sacc));
            check_eq("out_valid", out_valid, exp_v);
            check_eq("in_ready", in_ready, !(exp_v && !out_ready));
            if (exp_v) begin
                check_eq("sum", sum, exq[0].sum);
                check_eq("cout", cout, exq[0].cout);
                check_eq("ovf", ovf, exq[0].ovf);
            end
            stalled = exp_v && !out_ready;
            if (out_valid && out_ready && exq.size() > 0) begin
                void'(exq.pop_front());
                n_delivered++;
            end
            if (in_valid && in_ready) begin
                e      = model(x, y, add_n);
                e.acc  = cyc;
                e.sacc = stall_cnt;
                exq.push_back(e);
                last_acc = 1'b1;
            end
            if (stalled) stall_cnt++;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && exq.size() > 0; i++) step();
        check_eq("drain_empty", exq.size(), 0);
        repeat (2) step();
    endtask

    task automatic run_single(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                              input logic sub, input logic [N-1:0] es, input logic ec, input logic eo);
        in_valid = 1'b1; x = a; y = b; add_n = sub; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (LAT - 1) step();
        check_eq({tag, "_valid"}, out_valid, 1'b1);
        check_eq({tag, "_sum"}, sum, es);
        check_eq({tag, "_cout"}, cout, ec);
        check_eq({tag, "_ovf"}, ovf, eo);
        step();
    endtask

    initial begin
        int issued;
        int d0;
        repeat (3) step();
        rst = 1'b0;
        #1;
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_sum", sum, 16'h0000);
        check_eq("rst_cout", cout, 1'b0);
        check_eq("rst_ovf", ovf, 1'b0);
        check_eq("rst_in_ready", in_ready, 1'b1);

        run_single("add", 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0);
        run_single("wrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_single("chunk", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);
        run_single("sub_neg", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_single("sub_pos", 16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, 1'b0);
        run_single("ovf_add", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, OVF_ON);
        run_single("ovf_sub", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, OVF_ON);

        // back-to-back subtracts: model enforces order and consecutive delivery
        out_ready = 1'b1; in_valid = 1'b1; add_n = 1'b1;
        x = 16'h0005; y = 16'h0007; step();
        x = 16'h0007; y = 16'h0005; step();
        drain();

        // backpressure: 8 ops x=y=i, out_ready low on cycles 5..7
        issued = 0;
        d0 = n_delivered;
        for (int c = 0; c < 24; c++) begin
            in_valid  = (issued < 8);
            x         = 16'(issued);
            y         = 16'(issued);
            add_n     = 1'b0;
            out_ready = !(c >= 5 && c <= 7);
            #1;
            if (c >= 5 && c <= 7) check_eq("bp_in_ready", in_ready, 1'b0);
            step();
            if (last_acc) issued++;
        end
        drain();
        check_eq("bp_delivered", n_delivered - d0, 8);

        // reset mid-stream with 3 operations in flight
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            x = 16'($urandom); y = 16'($urandom); add_n = 1'($urandom);
            step();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("rst_mid_out_valid", out_valid, 1'b0);
        repeat (6) step();
        run_single("post_rst", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

        // random traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(3, 0) != 0);
            x         = 16'($urandom);
            y         = 16'($urandom);
            add_n     = 1'($urandom);
            out_ready = ($urandom_range(3, 0) != 0);
            step();
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/adder_subtractor_pipe_nbit.md
# adder_subtractor_pipe_nbit

Pipelined, parametrised n-bit adder/subtractor that accepts one operation per cycle through a valid/ready handshake and returns results after a fixed latency. The carry chain is split into `STAGES` equal chunks, one chunk per pipeline register, so wide operands close timing at high clock rates. It sits between operand producers and any downstream consumer that can apply backpressure, and replaces the purely combinational n-bit adder/subtractor wherever width or clock rate demands pipelining.

## Interface
Parameters:
- `n`: default 16. Operand width in bits; must be ≥ 2.
- `STAGES`: default 4. Number of pipeline stages; `n % STAGES == 0`, `1 ≤ STAGES ≤ n`.

Ports:
- `clk`  input  1  Single clock; all logic is rising-edge.
- `rst`  input  1  Synchronous, active-high reset.
- `in_valid`  input  1  Operand set `x`/`y`/`add_n` is valid this cycle.
- `in_ready`  output  1  Block accepts the operand set this cycle.
- `x`  input  n  Operand A.
- `y`  input  n  Operand B.
- `add_n`  input  1  0 selects add (x+y); 1 selects subtract (x−y = x+~y+1).
- `out_valid`  output  1  `sum`/`cout`/`ovf` hold a valid result.
- `out_ready`  input  1  Consumer takes the result this cycle.
- `sum`  output  n  Result modulo 2^n.
- `cout`  output  1  Carry out of the MSB. For subtract, 1 means no borrow (x ≥ y, unsigned).
- `ovf`  output  1  Two's-complement signed overflow (see Configuration).

## Operation
- Chunk width `C = n/STAGES`. Stage k (0..STAGES−1) adds bits [k·C +: C] of x and (y ^ {n{add_n}}), plus the carry registered by stage k−1. Stage 0 carry-in is `add_n`.
- Operands for higher chunks are carried forward in skew registers. Completed low chunks are carried forward alongside them, so the final stage presents the full `sum` aligned.
- Each stage has a valid bit. An operation enters stage 0 on a cycle where `in_valid && in_ready`.
- Global advance enable: `adv = !(out_valid && !out_ready)`. When `adv` is 1, all stages shift by one, bubbles included. When `adv` is 0, all stage registers hold.
- `in_ready = adv`. It is combinational from `out_valid` and `out_ready`; it does not depend on `in_valid`.
- Transfer rules:
  - A result is consumed on a cycle where `out_valid && out_ready`.
  - An operation is accepted on a cycle where `in_valid && in_ready`.
  - Both may occur in the same cycle.
- Results are delivered strictly in acceptance order. No operation is dropped or duplicated.
- `sum`, `cout` and `ovf` remain stable while `out_valid && !out_ready`.
- Arithmetic: `{cout, sum} = x + (y ^ {n{add_n}}) + add_n`, evaluated at width n+1.
- Reset: on a `rst` edge, every valid bit clears and every data register clears to 0. Operations in flight are discarded and are never presented. Reset has priority over `adv` and over acceptance.

## Timing
- Reset values:
  - `out_valid` = 0, `sum` = 0, `cout` = 0, `ovf` = 0.
  - `in_ready` = 1 on the first cycle after reset.
- Latency: operation accepted at edge T presents `out_valid` = 1 after edge T+STAGES when no stall occurs. With `STAGES` = 1 the block is a single registered adder with 1-cycle latency.
- Throughput: one operation per cycle while `out_ready` is held at 1.
- Each stall cycle (`adv` = 0) extends the latency of every operation in flight by exactly 1.
- Pipeline full and output blocked: `in_ready` = 0 until the cycle `out_ready` rises. On that cycle the result is consumed and a new operand set is accepted.
- `in_valid` deasserted: the bubble propagates. `out_valid` drops STAGES cycles later for one cycle per bubble.

## Configuration
- `ADDSUB_OVF_EN` defined:
  - Stage STAGES−1 also registers the carry into the MSB.
  - `ovf = carry_into_msb ^ cout`, presented with `sum`.
- `ADDSUB_OVF_EN` not defined:
  - `ovf` is tied to 0.
  - No MSB-carry register exists.
  - The port list is unchanged.

## Test plan
All scenarios use n = 16, STAGES = 4.
- Add, no stall: x = 0x1234, y = 0x0FFF, add_n = 0 accepted at cycle 0. Required: `out_valid` = 1 at cycle 4 with `sum` = 0x2233, `cout` = 0.
- Chunk-boundary carry: 0xFFFF + 0x0001 (add). Required: `sum` = 0x0000, `cout` = 1. Also 0x00FF + 0x0001 (add). Required: `sum` = 0x0100, `cout` = 0.
- Subtract:
  - 0x0005 − 0x0007. Required: `sum` = 0xFFFE, `cout` = 0.
  - 0x0007 − 0x0005. Required: `sum` = 0x0002, `cout` = 1.
  - Issue the two operations back-to-back. Required: results appear on consecutive cycles in issue order.
- Backpressure: 8 back-to-back operations with x = i, y = i, add_n = 0, and `out_ready` = 0 on cycles 5–7. Required:
  - `in_ready` = 0 on cycles 5–7.
  - Outputs hold steady during the stall.
  - Results 0, 2, 4, …, 14 are delivered in order with none lost.
- Signed overflow: 0x7FFF + 0x0001 (add). Required: `sum` = 0x8000, `ovf` = 1 with `ADDSUB_OVF_EN`, `ovf` = 0 without it. Also 0x8000 − 0x0001 (subtract). Required: `sum` = 0x7FFF, `ovf` = 1 with `ADDSUB_OVF_EN`.
- Reset mid-stream: 3 operations in flight, then `rst` = 1 for 1 cycle. Required:
  - `out_valid` = 0 the cycle after reset.
  - None of the 3 results ever appears.
  - A new operation 0x0001 + 0x0001 yields 0x0002 exactly 4 cycles after acceptance.
